// File: rtl/shr_iter.sv
// Iterative 32-bit right shifter (logical/arithmetic), one bit per clock; start->done latency 1+shamt cycles.
// start is accepted only in IDLE; requests while busy are dropped, never queued.
module shr_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [4:0]  shamt,
    input  logic        arith,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] data;
    logic [4:0]  cnt;
    logic        mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            data  <= 32'd0;
            cnt   <= 5'd0;
            mode  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        data <= in;
                        cnt  <= shamt;
                        mode <= arith;
                    end
                end
                SHIFT: begin
                    // fill bit is the sign bit in arithmetic mode, zero otherwise
                    data <= {mode & data[31], data[31:1]};
                    cnt  <= cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (shamt == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == 5'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out = data;

endmodule

// File: tb/tb_shr_iter.sv
// Directed-vector bench for shr_iter with hand-computed results and latencies.
module tb_shr_iter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] din;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] dout;
    logic        busy;
    logic        done;

    int nvec;
    int nmis;

    shr_iter dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (din),
        .shamt (shamt),
        .arith (arith),
        .out   (dout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; start is presented for one cycle (cycle C).
    task automatic op(input string tag, input logic [31:0] a, input logic [4:0] s,
                      input logic ar, input logic [31:0] exp);
        int   lat;
        logic busy_bad;
        start = 1'b1; din = a; shamt = s; arith = ar;
        @(negedge clk);
        start = 1'b0; din = 32'hDEAD_BEEF; shamt = 5'd17; arith = ~ar;
        lat = 1;
        busy_bad = 1'b0;
        while (!done && lat < 40) begin
            if (!busy) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, 32'(s) + 32'd1);
        chk({tag, " result"}, dout, exp);
        chk({tag, " busy at done"}, {31'd0, busy}, 32'd1);
        chk({tag, " busy before done"}, {31'd0, busy_bad}, 32'd0);
        @(negedge clk);
        chk({tag, " idle flags"}, {30'd0, busy, done}, 32'd0);
        chk({tag, " result held"}, dout, exp);
    endtask

    initial begin
        int ndone;
        int dlat;
        logic [31:0] dat_done;
        nvec = 0;
        nmis = 0;

        // reset asserted together with start: reset wins
        reset = 1'b1; start = 1'b1; din = 32'hFFFF_FFFF; shamt = 5'd3; arith = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset out", dout, 32'd0);
        chk("reset flags", {30'd0, busy, done}, 32'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post reset flags", {30'd0, busy, done}, 32'd0);

        op("sra4",   32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000);
        op("srl4",   32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000);
        op("sh0",    32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678);
        op("sra31",  32'h8000_0001, 5'd31, 1'b1, 32'hFFFF_FFFF);
        op("srl31",  32'h8000_0001, 5'd31, 1'b0, 32'h0000_0001);
        op("sra3pos", 32'h7FFF_FFFF, 5'd3, 1'b1, 32'h0FFF_FFFF);
        op("sra1",   32'hC000_0000, 5'd1,  1'b1, 32'hE000_0000);

        // start pulses during SHIFT (C+2) and DONE (C+5) must be ignored
        start = 1'b1; din = 32'h0000_00F0; shamt = 5'd4; arith = 1'b0;
        ndone = 0; dlat = 0; dat_done = 32'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                dlat = k;
                dat_done = dout;
            end
            start = 1'b0;
            if (k == 2 || k == 5) begin
                start = 1'b1; din = 32'hFFFF_FFFF; shamt = 5'd0; arith = 1'b1;
            end
        end
        start = 1'b0;
        chk("ign done count", ndone, 32'd1);
        chk("ign latency", dlat, 32'd5);
        chk("ign result", dat_done, 32'h0000_000F);
        chk("ign held", dout, 32'h0000_000F);
        chk("ign idle", {30'd0, busy, done}, 32'd0);

        // reset at C+3 aborts the operation
        start = 1'b1; din = 32'hF000_0000; shamt = 5'd10; arith = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort out", dout, 32'd0);
        chk("abort flags", {30'd0, busy, done}, 32'd0);
        op("after abort", 32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/shr_iter.md
Name: shr_iter

Overview:
- Iterative 32-bit right shifter, the right-direction counterpart of the fixed left shift used in branch-target generation.
- Supports logical mode (zero fill) and arithmetic mode (sign fill, replicating bit 31 the same way sign extension does).
- Shifts one bit per clock under a start/busy/done handshake.
- Serves as the SRL/SRA/SRAV execution unit for the multi-cycle datapath.

Parameters:
- none (width fixed at 32, shift amount fixed at 5 bits)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- in  input  32  operand; captured on accepted start
- shamt  input  5  shift amount 0..31; captured on accepted start
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured on accepted start
- out  output  32  shift register contents; final result valid when done=1, held afterwards
- busy  output  1  1 while the operation is in SHIFT or DONE
- done  output  1  one-cycle pulse marking the final result

Behaviour:
- One clock; reset is synchronous and active-high: at a rising clk edge with reset=1, state=IDLE, out=0, cnt=0, mode=0, busy=0, done=0. Reset overrides start.
- Internal state: state {IDLE, SHIFT, DONE}; data register (drives out); cnt[4:0]; mode bit (latched arith).
- IDLE:
  - busy=0, done=0, out holds the last result.
  - On start=1 at an edge: data<=in, cnt<=shamt, mode<=arith.
  - Next state is DONE if shamt==0, otherwise SHIFT.
- SHIFT:
  - busy=1.
  - Each edge: data<={fill, data[31:1]}, where fill = mode ? data[31] : 1'b0; cnt<=cnt-1.
  - If cnt==1 at that edge, next state is DONE; otherwise stay in SHIFT.
  - out shows intermediate values and is not valid as a result.
- DONE:
  - busy=1, done=1 for exactly one cycle.
  - Next edge: go to IDLE unconditionally; data is unchanged.
- Latency: start sampled in cycle C -> done high in cycle C+1+shamt (shamt=0 -> C+1; shamt=31 -> C+32).
- Throughput: the next start can be accepted in the cycle after done, i.e. in IDLE.
- start while busy=1 (SHIFT or DONE) is ignored, with no queuing. in/shamt/arith are don't-care outside the accepting edge.
- Result equals in >> shamt (logical) or $signed(in) >>> shamt (arithmetic).
- Arithmetic shift of a negative operand by 31 gives 0xFFFFFFFF. Logical shift by 31 gives in[31] in bit 0.
- Reset mid-operation aborts: no done pulse, out=0. The aborted start is not remembered.
- start and reset high together: reset wins, and the operation is not accepted.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then start with in=0x80000000, shamt=4, arith=1 in cycle C -> done=1 only in cycle C+5, out=0xF8000000, busy=1 for C+1..C+5.
- Same operands with arith=0 -> out=0x08000000 at done (C+5); out holds 0x08000000 in the following idle cycles.
- in=0x12345678, shamt=0, arith=1 -> done in C+1, out=0x12345678, never enters SHIFT.
- in=0x80000001, shamt=31: arith=1 -> out=0xFFFFFFFF at C+32; arith=0 -> out=0x00000001 at C+32.
- Start in=0x000000F0, shamt=4, arith=0; pulse start again with in=0xFFFFFFFF during SHIFT and during DONE -> both ignored, out=0x0000000F, exactly one done pulse.
- Start in=0xF0000000, shamt=10; assert reset at C+3 -> from the next edge out=0, busy=0, done=0, and no done pulse follows. A start in the next cycle with in=0x00000100, shamt=8, arith=0 -> out=0x00000001 at done.
